// File: rtl/pwm_compare.sv
// pwm_compare: PWM generator on an external free-running count, with a
//   double-buffered duty (valid/ready), wrap pulse, sticky irq and stall flag.
// Latency: o_pwm_out, o_period_done, o_irq, o_stall are registered, 1 cycle after i_q.
// Backpressure: o_duty_ready is low while a duty waits in the shadow buffer.
//   It returns high the cycle after the wrap that applies that duty.
//
// Ports:
//   i_clk, i_rst_n               clock; asynchronous active-low reset
//   i_q                          count from the upstream counter (PWM timebase)
//   i_duty_valid/i_duty_data     duty offer, in counts per period
//   o_duty_ready                 shadow buffer free (comb. from r_pending only)
//   o_pwm_out                    registered PWM output
//   o_period_done                one-cycle pulse per counter wrap
//   o_irq / i_irq_ack            sticky wrap interrupt and its clear
//   o_stall                      timebase has stopped changing
module pwm_compare #(
  parameter int WIDTH       = 4,
  parameter int STALL_LIMIT = 8   // must be >= 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_duty_valid,
  input  logic [WIDTH-1:0] i_duty_data,
  output logic             o_duty_ready,
  output logic             o_pwm_out,
  output logic             o_period_done,
  output logic             o_irq,
  input  logic             i_irq_ack,
  output logic             o_stall
);

  // Wide enough to hold STALL_LIMIT itself, where the counter saturates.
  localparam int SCW = $clog2(STALL_LIMIT + 1);
  localparam logic [SCW-1:0] STALL_MAX = SCW'(STALL_LIMIT);

  logic [WIDTH-1:0] r_q_prev;
  logic [WIDTH-1:0] r_active_duty;
  logic [WIDTH-1:0] r_shadow_duty;
  logic             r_pending;
  logic [SCW-1:0]   r_stall_cnt;

  logic             w_wrap;
  logic             w_xfer;
  logic             w_apply;
  logic [WIDTH-1:0] w_duty_eff;
  logic [SCW-1:0]   w_stall_cnt_nxt;

  // ---------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------

  // Only a max->0 step is a wrap; 0->0 (e.g. first sample after reset, or a
  // counter held in reset) must not produce a period boundary.
  assign w_wrap = (r_q_prev == {WIDTH{1'b1}}) && (i_q == '0);

  // Ready depends on the register alone, so valid never loops back to ready.
  assign o_duty_ready = !r_pending;
  assign w_xfer       = i_duty_valid && !r_pending;

  // Shadow moves into active at the wrap that sees it pending.
  assign w_apply = w_wrap && r_pending;

  // In the wrap cycle the q=0 sample must already use the new duty, so the
  // shadow value bypasses active for that one compare.
  assign w_duty_eff = w_apply ? r_shadow_duty : r_active_duty;

  always_comb begin
    w_stall_cnt_nxt = '0;
    if (i_q == r_q_prev) begin
      if (r_stall_cnt == STALL_MAX) begin
        w_stall_cnt_nxt = r_stall_cnt;
      end else begin
        w_stall_cnt_nxt = r_stall_cnt + SCW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Timebase history and stall detection
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q_prev    <= '0;
      r_stall_cnt <= '0;
      o_stall     <= 1'b0;
    end else begin
      r_q_prev    <= i_q;
      r_stall_cnt <= w_stall_cnt_nxt;
      o_stall     <= (w_stall_cnt_nxt == STALL_MAX);
    end
  end

  // ---------------------------------------------------------------------
  // Duty double buffer
  // ---------------------------------------------------------------------
  // A transfer needs r_pending == 0 and an apply needs r_pending == 1, so the
  // two never collide in one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_duty <= '0;
      r_active_duty <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_shadow_duty <= i_duty_data;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_active_duty <= r_shadow_duty;
        r_pending     <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // PWM compare and wrap outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pwm_out     <= 1'b0;
      o_period_done <= 1'b0;
      o_irq         <= 1'b0;
    end else begin
      o_pwm_out     <= (i_q < w_duty_eff);
      o_period_done <= w_wrap;
      // Set has priority so a wrap coinciding with an ack is not lost.
      if (w_wrap) begin
        o_irq <= 1'b1;
      end else if (i_irq_ack) begin
        o_irq <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_compare.md
# pwm_compare

Downstream consumer of the free-running `counter` stage: samples its count `q` as a PWM timebase and produces a registered PWM output. A new duty value, accepted through a valid/ready handshake, is double-buffered and applied only at counter wrap, so no glitched periods occur. Wrap events raise a one-cycle pulse and a sticky interrupt. A stall detector flags a timebase that has stopped counting, such as a counter held in reset.

## Interface
- `WIDTH`, 4, width of `q` and duty values; must match the counter's `WIDTH`.
- `STALL_LIMIT`, 8, number of consecutive unchanged `q` samples that raises `stall`; must be at least 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `q`  in  WIDTH  count from the upstream counter.
- `duty_valid`  in  1  a duty value is offered.
- `duty_data`  in  WIDTH  offered duty value, in counts per period.
- `duty_ready`  out  1  shadow buffer is free; a transfer occurs when valid && ready.
- `pwm_out`  out  1  registered PWM output.
- `period_done`  out  1  one-cycle pulse per counter wrap.
- `irq`  out  1  sticky wrap interrupt.
- `irq_ack`  in  1  clears `irq`.
- `stall`  out  1  timebase has stopped.

## Operation
- Registered state: `q_prev`, `active_duty`, `shadow_duty`, `pending`, `stall_cnt` (saturating at `STALL_LIMIT`), and all outputs except `duty_ready`.
- Wrap is the combinational condition `q_prev == {WIDTH{1'b1}}` && `q == 0`. A transition from 0 to 0, including the first sample after reset, is not a wrap.
- Handshake:
  - `duty_ready = !pending`, driven combinationally from the register.
  - On valid && ready, `shadow_duty <= duty_data` and `pending <= 1`.
  - `duty_data` is ignored while ready is low. The sender must hold valid and data until the transfer occurs.
- Duty update:
  - In a wrap cycle with `pending` = 1: `active_duty <= shadow_duty` and `pending <= 0`.
  - A transfer in the same cycle as a wrap cannot happen while `pending` = 1. A transfer in a wrap cycle with `pending` = 0 loads the shadow, and that value applies at the next wrap.
- PWM:
  - `duty_eff` = `shadow_duty` if (wrap && pending), otherwise `active_duty`.
  - `pwm_out <= (q < duty_eff)`, an unsigned WIDTH-bit compare.
  - Duty 0 gives constant low. The maximum duty 2^WIDTH−1 gives high on all counts except the top count. A 100 % duty is not supported.
- Wrap outputs:
  - `period_done <= wrap`.
  - `irq` is set by wrap and cleared by `irq_ack`. If wrap and ack occur in the same cycle, set wins and `irq` stays 1.
- Stall:
  - If `q == q_prev`, `stall_cnt` increments, saturating at `STALL_LIMIT`. Otherwise it returns to 0.
  - `stall <= (next stall_cnt == STALL_LIMIT)`. Any change of `q` clears `stall` on the next edge.
- Reset state: `q_prev` 0, `active_duty` 0, `shadow_duty` 0, `pending` 0, `stall_cnt` 0.
- Reset values of outputs: `pwm_out` 0, `period_done` 0, `irq` 0, `stall` 0, `duty_ready` 1.
- Reset applies immediately at any point, including mid-period. Any pending duty is discarded.

## Timing
- `pwm_out` lags `q` by exactly 1 cycle.
- With a free-running counter, the period is 2^WIDTH cycles.
- `period_done` is high for exactly the cycle after the edge where `q` changes from max to 0.
- `irq` rises together with `period_done`.
- `duty_ready` falls the cycle after a transfer and rises the cycle after the next wrap.
- A new duty affects `pwm_out` starting at the first PWM sample of the next period, which is the output for `q` = 0.
- `stall` rises `STALL_LIMIT` cycles after `q` stops changing. It falls 1 cycle after `q` changes.
- No combinational path exists from `duty_valid` to `duty_ready`.

## Test plan
- Reset: hold `rst_n` low for 2 cycles → `pwm_out`, `period_done`, `irq` and `stall` are 0; `duty_ready` is 1. Release with the counter running → no `period_done` before `q` goes from 15 to 0.
- Duty 5, WIDTH = 4: offer 5 mid-period → `duty_ready` drops the next cycle. Output stays low for the rest of that period. After the wrap, `pwm_out` is high while `q` is 0–4 (lagging 1 cycle) and low while `q` is 5–15, repeating every 16 cycles. `duty_ready` returns to 1.
- Back-to-back loads: offer 3, then hold valid with 12 → 12 is accepted only after the wrap that applies 3. Output runs one period at duty 3, then duty 12. Duty 0 gives constant low; duty 15 gives low only when `q` = 15.
- Wrap and interrupt: `period_done` is a single-cycle pulse once per 16 cycles and `irq` sets. `irq_ack` clears `irq`. Asserting `irq_ack` in the same cycle as a wrap → `irq` stays 1.
- Stall: hold the counter's `rst_n` low so `q` stays 0 for 10 cycles → `stall` = 1 from the 8th unchanged sample, with no `period_done`. Release → `stall` = 0 one cycle after `q` becomes 1.
- Mid-operation reset: with `pending` = 1 and `pwm_out` high, pulse `rst_n` low asynchronously, away from a clock edge → all outputs reset immediately. The pending duty is lost and the output stays at duty 0 until a new transfer and a wrap.
